rv32_barrel_fetch: RTL and testbench

//  Parametrised multi-hart (barrel) fetch unit for the pito core, replacing the single-PC fetch stage.

---
 rtl/rv32_barrel_fetch_if.sv | 33 +++
 rtl/rv32_barrel_fetch.sv | 147 ++++++++++++++
 tb/tb_rv32_barrel_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_barrel_fetch_if.sv
// Fetch-unit bus bundle: schedule/redirect controls in, i_mem read port and tagged fetch out.
// master = fetch unit side, slave = surrounding core / environment side.
interface rv32_barrel_fetch_if #(
  parameter int unsigned NUM_HARTS   = 8,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned IMEM_ADDR_W = 12
);
  localparam int unsigned HID_W = $clog2(NUM_HARTS);

  logic                        rv32_io_program;
  logic [NUM_HARTS-1:0]        hart_en;
  logic                        stall;
  logic                        redirect_valid;
  logic [HID_W-1:0]            redirect_hart;
  logic [PC_W-1:0]             redirect_pc;

  logic [IMEM_ADDR_W-1:0]      imem_rd_addr;
  logic                        imem_rd_en;
  logic                        fetch_valid;
  logic [HID_W-1:0]            fetch_hart;
  logic [PC_W-1:0]             fetch_pc;
  logic [NUM_HARTS*PC_W-1:0]   hart_pc;

  modport master (
    input  rv32_io_program, hart_en, stall, redirect_valid, redirect_hart, redirect_pc,
    output imem_rd_addr, imem_rd_en, fetch_valid, fetch_hart, fetch_pc, hart_pc
  );

  modport slave (
    output rv32_io_program, hart_en, stall, redirect_valid, redirect_hart, redirect_pc,
    input  imem_rd_addr, imem_rd_en, fetch_valid, fetch_hart, fetch_pc, hart_pc
  );
endinterface

// File: rtl/rv32_barrel_fetch.sv
// Barrel fetch unit: one PC per hart, one i_mem read per cycle round-robin over enabled harts,
// with writeback redirects and hart/PC tagging aligned to the 1-cycle i_mem read latency.
module rv32_barrel_fetch #(
  parameter int unsigned     NUM_HARTS     = 8,
  parameter int unsigned     PC_W          = 32,
  parameter int unsigned     IMEM_ADDR_W   = 12,
  parameter logic [PC_W-1:0] RESET_ADDRESS = '0
) (
  input  logic                  rv32_io_clk,
  input  logic                  rv32_io_rst_n,
  rv32_barrel_fetch_if.master   bus
);
  localparam int unsigned HID_W = $clog2(NUM_HARTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [HID_W-1:0]       rr_q, rr_d, pick;
  logic [PC_W-1:0]        pc_q [NUM_HARTS];
  logic [PC_W-1:0]        pc_d [NUM_HARTS];

  // Stage A: read presented to i_mem; stage B: word on i_mem q
  logic [IMEM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                   rd_en_q, rd_en_d;
  logic [HID_W-1:0]       a_hart_q, a_hart_d;
  logic [PC_W-1:0]        a_pc_q, a_pc_d;
  logic                   a_live_q, a_live_d;
  logic                   fv_q, fv_d;
  logic [HID_W-1:0]       fh_q, fh_d;
  logic [PC_W-1:0]        fpc_q, fpc_d;

  logic                   go, issue;

  // First enabled hart at or after the rr pointer; descending scan lets the nearest win
  always_comb begin
    pick = rr_q;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (bus.hart_en[HID_W'(rr_q + HID_W'(i))]) begin
        pick = HID_W'(rr_q + HID_W'(i));
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    go      = !bus.rv32_io_program && (|bus.hart_en);
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_RUN;
      ST_RUN: begin
        if (!go)            state_d = ST_IDLE;
        else if (bus.stall) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!go)             state_d = ST_IDLE;
        else if (!bus.stall) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Issue, pipeline advance/drain/hold and PC updates
  always_comb begin
    rr_d      = rr_q;
    pc_d      = pc_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    a_hart_d  = a_hart_q;
    a_pc_d    = a_pc_q;
    a_live_d  = a_live_q;
    fv_d      = fv_q;
    fh_d      = fh_q;
    fpc_d     = fpc_q;
    issue     = (state_q == ST_RUN) && go && !bus.stall;

    if (issue) begin
      rd_addr_d  = pc_q[pick][IMEM_ADDR_W+1:2];
      rd_en_d    = 1'b1;
      a_hart_d   = pick;
      a_pc_d     = pc_q[pick];
      a_live_d   = !(bus.redirect_valid && (bus.redirect_hart == pick));
      pc_d[pick] = pc_q[pick] + PC_W'(4);
      rr_d       = HID_W'(pick + HID_W'(1));
      fv_d       = a_live_q;
      fh_d       = a_hart_q;
      fpc_d      = a_pc_q;
    end else if ((state_q == ST_IDLE) || !go) begin
      // Let the in-flight read land on q, then go quiet
      a_live_d = 1'b0;
      fv_d     = a_live_q;
      fh_d     = a_hart_q;
      fpc_d    = a_pc_q;
    end else if (bus.redirect_valid && (bus.redirect_hart == fh_q)) begin
      fv_d = 1'b0;
    end

    // Redirect applied last so it overrides the +4 of a same-cycle issue
    if (bus.redirect_valid) begin
      pc_d[bus.redirect_hart] = bus.redirect_pc & ~PC_W'(3);
    end
  end

  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      rr_q      <= '0;
      for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= RESET_ADDRESS;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      a_hart_q  <= '0;
      a_pc_q    <= '0;
      a_live_q  <= 1'b0;
      fv_q      <= 1'b0;
      fh_q      <= '0;
      fpc_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      pc_q      <= pc_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      a_hart_q  <= a_hart_d;
      a_pc_q    <= a_pc_d;
      a_live_q  <= a_live_d;
      fv_q      <= fv_d;
      fh_q      <= fh_d;
      fpc_q     <= fpc_d;
    end
  end

  assign bus.imem_rd_addr = rd_addr_q;
  assign bus.imem_rd_en   = rd_en_q;
  assign bus.fetch_valid  = fv_q;
  assign bus.fetch_hart   = fh_q;
  assign bus.fetch_pc     = fpc_q;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart_pc
    assign bus.hart_pc[g*PC_W +: PC_W] = pc_q[g];
  end
endmodule

// File: tb/tb_rv32_barrel_fetch.sv
// Bench for rv32_barrel_fetch: directed scenarios plus random traffic against a
// cycle-level behavioural model built from the schedule/redirect rules.
module tb_rv32_barrel_fetch;
  localparam int unsigned N  = 8;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_barrel_fetch_if #(.NUM_HARTS(N), .PC_W(PW), .IMEM_ADDR_W(AW)) bus ();

  rv32_barrel_fetch #(
    .NUM_HARTS(N), .PC_W(PW), .IMEM_ADDR_W(AW), .RESET_ADDRESS(32'h0)
  ) dut (
    .rv32_io_clk  (clk),
    .rv32_io_rst_n(rst_n),
    .bus          (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = not fetching, 1 = fetching, 2 = held by stall
  int          m_mode, m_rr;
  logic [31:0] m_pc [N];
  bit          fl_live;
  int          fl_hart;
  logic [31:0] fl_pc;
  logic [31:0] e_addr, e_fpc;
  bit          e_en, e_fv;
  int          e_fh;

  int          q_addr [$];
  int          q_fh   [$];
  logic [31:0] q_fpc  [$];
  bit          prev_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rr = 0;
    for (int h = 0; h < N; h++) m_pc[h] = 32'h0;
    fl_live = 0; fl_hart = 0; fl_pc = 0;
    e_addr = 0; e_en = 0; e_fv = 0; e_fh = 0; e_fpc = 0;
    prev_stall = 0;
  endtask

  task automatic model_step();
    bit go;
    int h;
    go = !bus.rv32_io_program && (bus.hart_en != 0);
    if (m_mode == 1 && go && !bus.stall) begin
      h = 0;
      for (int k = N - 1; k >= 0; k--) if (bus.hart_en[(m_rr + k) % N]) h = (m_rr + k) % N;
      e_fv = fl_live; e_fh = fl_hart; e_fpc = fl_pc;
      e_addr = (m_pc[h] / 4) % (1 << AW);
      e_en = 1;
      fl_live = !(bus.redirect_valid && int'(bus.redirect_hart) == h);
      fl_hart = h; fl_pc = m_pc[h];
      m_pc[h] = m_pc[h] + 32'd4;
      m_rr = (h + 1) % N;
    end else if (m_mode == 0 || !go) begin
      e_en = 0; e_fv = fl_live; e_fh = fl_hart; e_fpc = fl_pc; fl_live = 0;
    end else begin
      e_en = 0;
      if (bus.redirect_valid && int'(bus.redirect_hart) == e_fh) e_fv = 0;
    end
    if (bus.redirect_valid) m_pc[bus.redirect_hart] = bus.redirect_pc & 32'hFFFF_FFFC;
    m_mode = !go ? 0 : (m_mode == 0 ? 1 : (bus.stall ? 2 : 1));
  endtask

  task automatic compare_all();
    check("imem_rd_addr", 64'(bus.imem_rd_addr), 64'(e_addr));
    check("imem_rd_en",   64'(bus.imem_rd_en),   64'(e_en));
    check("fetch_valid",  64'(bus.fetch_valid),  64'(e_fv));
    if (e_fv) begin
      check("fetch_hart", 64'(bus.fetch_hart), 64'(e_fh));
      check("fetch_pc",   64'(bus.fetch_pc),   64'(e_fpc));
    end
    for (int h = 0; h < N; h++)
      check($sformatf("hart_pc[%0d]", h), 64'(bus.hart_pc[h*PW +: PW]), 64'(m_pc[h]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (bus.imem_rd_en) q_addr.push_back(int'(bus.imem_rd_addr));
    // Only record fetches that moved, not ones held across a stall
    if (bus.fetch_valid && !bus.stall && !prev_stall) begin
      q_fh.push_back(int'(bus.fetch_hart));
      q_fpc.push_back(bus.fetch_pc);
    end
    prev_stall = bus.stall;
    @(negedge clk);
  endtask

  task automatic clear_q();
    q_addr.delete(); q_fh.delete(); q_fpc.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rd_addr"}, 64'(bus.imem_rd_addr), 64'h0);
    check({tag, "_rd_en"},   64'(bus.imem_rd_en),   64'h0);
    check({tag, "_fvalid"},  64'(bus.fetch_valid),  64'h0);
    check({tag, "_fhart"},   64'(bus.fetch_hart),   64'h0);
    check({tag, "_fpc"},     64'(bus.fetch_pc),     64'h0);
    for (int h = 0; h < N; h++) check({tag, "_hart_pc"}, 64'(bus.hart_pc[h*PW +: PW]), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_rr_order(input string tag, input int min_len);
    check({tag, "_len"}, 64'(q_fh.size() >= min_len), 64'h1);
    for (int i = 1; i < q_fh.size(); i++) check(tag, 64'(q_fh[i]), 64'((q_fh[i-1] + 1) % N));
  endtask

  initial begin
    int idx;
    bus.rv32_io_program = 1'b0;
    bus.hart_en         = 8'hFF;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_hart   = '0;
    bus.redirect_pc     = '0;
    model_reset();

    // All harts enabled from reset
    do_reset("rst0");
    clear_q();
    repeat (20) tick();
    for (int i = 0; i < 8; i++) check("all_addr", 64'(q_addr[i]), 64'h0);
    check("all_addr8", 64'(q_addr[8]), 64'h1);
    for (int i = 0; i < 16; i++) check("all_hart", 64'(q_fh[i]), 64'(i % 8));
    for (int i = 0; i < 8; i++) check("all_pc", 64'(q_fpc[i]), 64'h0);
    check("all_pc8", 64'(q_fpc[8]), 64'h4);

    // Harts 0 and 2 only
    do_reset("rst1");
    bus.hart_en = 8'b0000_0101;
    clear_q();
    repeat (10) tick();
    for (int i = 0; i < 8; i++) check("sparse_hart", 64'(q_fh[i]), 64'((i % 2) * 2));
    check("sparse_pc0", 64'(q_fpc[0]), 64'h0);
    check("sparse_pc2", 64'(q_fpc[2]), 64'h4);
    check("sparse_pc4", 64'(q_fpc[4]), 64'h8);
    check("sparse_h1pc", 64'(bus.hart_pc[1*PW +: PW]), 64'h0);

    // Redirect hart 3 in the cycle it issues
    do_reset("rst2");
    bus.hart_en = 8'hFF;
    for (int i = 0; i < 20 && !(m_mode == 1 && m_rr == 3); i++) tick();
    check("wait_h3_issue", 64'(m_mode == 1 && m_rr == 3), 64'h1);
    clear_q();
    bus.redirect_valid = 1'b1; bus.redirect_hart = 3'd3; bus.redirect_pc = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("redir_squash", 64'(bus.fetch_valid), 64'h0);
    repeat (12) tick();
    check("redir_addr", 64'(q_addr[8]), 64'h40);
    idx = -1;
    for (int i = q_fh.size() - 1; i >= 0; i--) if (q_fh[i] == 3) idx = i;
    check("redir_found", 64'(idx >= 0), 64'h1);
    if (idx >= 0) check("redir_pc", 64'(q_fpc[idx]), 64'h100);

    // Stall for three cycles mid-run
    clear_q();
    repeat (3) tick();
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b0;
    repeat (8) tick();
    check_rr_order("stall_order", 8);

    // Program mode mid-run
    clear_q();
    repeat (2) tick();
    bus.rv32_io_program = 1'b1;
    tick();
    check("prog_rd_en", 64'(bus.imem_rd_en), 64'h0);
    tick();
    check("prog_fvalid", 64'(bus.fetch_valid), 64'h0);
    tick();
    bus.rv32_io_program = 1'b0;
    repeat (12) tick();
    check_rr_order("prog_order", 10);

    // PC wrap at 2^32 on a single hart
    bus.hart_en = 8'h01; bus.stall = 1'b1;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_hart = 3'd0; bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    clear_q();
    repeat (6) tick();
    check("wrap_addr0", 64'(q_addr[0]), 64'hFFF);
    check("wrap_addr1", 64'(q_addr[1]), 64'h0);
    idx = -1;
    for (int i = q_fpc.size() - 1; i >= 0; i--) if (q_fpc[i] == 32'hFFFF_FFFC) idx = i;
    check("wrap_found", 64'(idx >= 0), 64'h1);
    if (idx >= 0) check("wrap_next_pc", 64'(q_fpc[idx + 1]), 64'h0);

    // Random traffic, with an asynchronous reset pulse in the middle
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 300; i++) begin
        bus.hart_en         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        bus.stall           = ($urandom_range(0, 4) == 0);
        bus.rv32_io_program = ($urandom_range(0, 19) == 0);
        bus.redirect_valid  = ($urandom_range(0, 5) == 0);
        bus.redirect_hart   = 3'($urandom);
        bus.redirect_pc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : 32'($urandom);
        tick();
      end
      if (phase == 0) do_reset("rst_mid");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
